// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an async PWM input,
// publishing one measurement per period and flagging stuck-high/stuck-low inputs.
module pwm_capture #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 65535,
  parameter int EXP_PERIOD = 256
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             pwm_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       duty8,
  output logic             period_ok,
  output logic             stuck_hi,
  output logic             stuck_lo
);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXP = CNT_W'(EXP_PERIOD);
  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic pwm_m_q, pwm_s_q, pwm_d_q;
  logic [CNT_W-1:0] r_q, r_d, h_tmp_q, h_tmp_d;
  logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
  logic [7:0] duty_q, duty_d;
  logic primed_q, primed_d, valid_q, valid_d, ok_q, ok_d;
  logic shi_q, shi_d, slo_q, slo_d;
  logic rise, fall, at_to, exp_hit;
  assign rise    = pwm_s_q & ~pwm_d_q;
  assign fall    = ~pwm_s_q & pwm_d_q;
  assign at_to   = r_q == TO;
  assign exp_hit = r_q == EXP;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pwm_m_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      pwm_m_q <= pwm_in;
      pwm_s_q <= pwm_m_q;
      pwm_d_q <= pwm_s_q;
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= SYNC;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    state_d = rise ? HIGH : SYNC;
      HIGH:    state_d = fall ? LOW : at_to ? SYNC : HIGH;
      LOW:     state_d = rise ? HIGH : at_to ? SYNC : LOW;
      default: state_d = SYNC;
    endcase
  end
  // A publish needs a prior full period; the arming rise never reports.
  always_comb begin
    r_d      = rise ? CNT_W'(1) : at_to ? r_q : r_q + CNT_W'(1);
    primed_d = primed_q;
    h_tmp_d  = h_tmp_q;
    valid_d  = 1'b0;
    high_d   = high_q;
    period_d = period_q;
    duty_d   = duty_q;
    ok_d     = ok_q;
    shi_d    = shi_q;
    slo_d    = slo_q;
    case (state_q)
      SYNC: begin
        if (rise) primed_d = 1'b0;
        else if (at_to) begin
          shi_d = pwm_s_q;
          slo_d = ~pwm_s_q;
        end
      end
      HIGH: begin
        if (fall) h_tmp_d = r_q;
        else if (at_to) begin
          shi_d = 1'b1;
          slo_d = 1'b0;
        end
      end
      LOW: begin
        if (rise) begin
          primed_d = 1'b1;
          if (primed_q) begin
            valid_d  = 1'b1;
            high_d   = h_tmp_q;
            period_d = r_q;
            ok_d     = exp_hit;
            duty_d   = exp_hit ? h_tmp_q[7:0] : 8'd0;
            shi_d    = 1'b0;
            slo_d    = 1'b0;
          end
        end else if (at_to) begin
          slo_d = 1'b1;
          shi_d = 1'b0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_q      <= '0;
      h_tmp_q  <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      ok_q     <= 1'b0;
      shi_q    <= 1'b0;
      slo_q    <= 1'b0;
    end else begin
      r_q      <= r_d;
      h_tmp_q  <= h_tmp_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      high_q   <= high_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      ok_q     <= ok_d;
      shi_q    <= shi_d;
      slo_q    <= slo_d;
    end
  end
  assign meas_valid = valid_q;
  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign duty8      = duty_q;
  assign period_ok  = ok_q;
  assign stuck_hi   = shi_q;
  assign stuck_lo   = slo_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM period lists and compares published measurements
// against expectations computed from the driven high/period lengths.
module tb_pwm_capture;
  localparam int T = 1000;
  typedef struct packed {
    int          c;
    logic [15:0] h;
    logic [15:0] p;
    logic [7:0]  d;
    logic        ok;
    logic [1:0]  sl;
  } meas_t;
  logic clk = 1'b0;
  logic n_rst, pwm_in;
  logic meas_valid, period_ok, stuck_hi, stuck_lo;
  logic [15:0] high_cnt, period_cnt;
  logic [7:0] duty8;
  meas_t mon[$], exp_q[$];
  int hq[$], pq[$], rc[$];
  int cyc = 0;
  int passed = 0, total = 0;
  logic prev_slo = 1'b0, both_seen = 1'b0;

  pwm_capture #(.TIMEOUT(T)) dut (
    .clk(clk), .n_rst(n_rst), .pwm_in(pwm_in), .meas_valid(meas_valid),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty8(duty8),
    .period_ok(period_ok), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (n_rst && meas_valid)
      mon.push_back({cyc, high_cnt, period_cnt, duty8, period_ok, prev_slo, stuck_lo});
    if (stuck_hi && stuck_lo) both_seen <= 1'b1;
    prev_slo <= stuck_lo;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    n_rst = 1'b0;
    pwm_in = lvl;
    repeat (3) tick();
    n_rst = 1'b1;
    mon.delete();
    rc.delete();
    repeat (4) tick();
  endtask

  function automatic void set_list(input int h, input int p, input int n);
    hq.delete();
    pq.delete();
    for (int i = 0; i < n; i++) begin
      hq.push_back(h);
      pq.push_back(p);
    end
  endfunction

  task automatic drive_list();
    for (int i = 0; i < hq.size(); i++) begin
      pwm_in = 1'b1;
      rc.push_back(cyc);
      repeat (hq[i]) tick();
      pwm_in = 1'b0;
      repeat (pq[i] - hq[i]) tick();
    end
    repeat (6) tick();
  endtask

  // Rise j (j >= 2) reports the period that began at rise j-1, 2 sync + 1 register later.
  function automatic void build_exp(input logic [1:0] sl0);
    meas_t e;
    exp_q.delete();
    for (int j = 2; j < rc.size(); j++) begin
      e.c  = rc[j] + 3;
      e.h  = 16'(hq[j-1]);
      e.p  = 16'(pq[j-1]);
      e.ok = pq[j-1] == 256;
      e.d  = e.ok ? 8'(hq[j-1]) : 8'd0;
      e.sl = (j == 2) ? sl0 : 2'b00;
      exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    pwm_in = 1'b0;
    #1;
    total++;
    if ({meas_valid, high_cnt, period_cnt, duty8, period_ok, stuck_hi, stuck_lo} !== '0)
      $display("FAIL reset_async got %h want 0", {meas_valid, high_cnt, period_cnt, duty8, period_ok, stuck_hi, stuck_lo});
    else passed++;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (10) tick();
    total++;
    if ({meas_valid, high_cnt, period_cnt, duty8, period_ok, stuck_hi, stuck_lo} !== '0)
      $display("FAIL reset_idle got %h want 0", {meas_valid, high_cnt, period_cnt, duty8, period_ok, stuck_hi, stuck_lo});
    else passed++;
  endtask

  task automatic test_nominal();
    do_reset(1'b0);
    set_list(100, 256, 5);
    drive_list();
    build_exp(2'b00);
    total++;
    if (mon.size() !== 3) $display("FAIL nominal_count got %0d want 3", mon.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) $display("FAIL nominal[%0d] got %h want %h", i, mon[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_duty_extremes();
    do_reset(1'b0);
    set_list(256, 256, 0);
    hq = '{10, 1, 255, 7};
    pq = '{256, 256, 256, 256};
    drive_list();
    build_exp(2'b00);
    total++;
    if (mon.size() !== exp_q.size()) $display("FAIL extremes_count got %0d want %0d", mon.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) $display("FAIL extremes[%0d] got %h want %h", i, mon[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_off_period();
    do_reset(1'b0);
    set_list(50, 300, 4);
    drive_list();
    build_exp(2'b00);
    total++;
    if (mon.size() !== exp_q.size()) $display("FAIL off_count got %0d want %0d", mon.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) $display("FAIL off_period[%0d] got %h want %h", i, mon[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int p;
    do_reset(1'b0);
    hq.delete();
    pq.delete();
    for (int i = 0; i < 10; i++) begin
      p = ($urandom_range(0, 1) == 1) ? 256 : int'($urandom_range(2, 600));
      pq.push_back(p);
      hq.push_back(int'($urandom_range(1, p - 1)));
    end
    drive_list();
    build_exp(2'b00);
    total++;
    if (mon.size() !== exp_q.size()) $display("FAIL random_count got %0d want %0d", mon.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) $display("FAIL random[%0d] got %h want %h", i, mon[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_stuck_lo();
    int e;
    do_reset(1'b0);
    set_list(100, 256, 4);
    drive_list();
    e = rc[3];
    while (cyc < e + T + 2) @(negedge clk);
    total++;
    if (stuck_lo !== 1'b0) $display("FAIL stuck_lo_early got %b want 0", stuck_lo);
    else passed++;
    @(negedge clk);
    total++;
    if ({stuck_hi, stuck_lo} !== 2'b01) $display("FAIL stuck_lo_set got %b want 01", {stuck_hi, stuck_lo});
    else passed++;
    total++;
    if ({mon.size() == 2, high_cnt, period_cnt} !== {1'b1, 16'd100, 16'd256})
      $display("FAIL stuck_lo_hold got n=%0d h=%0d p=%0d want n=2 h=100 p=256", mon.size(), high_cnt, period_cnt);
    else passed++;
    tick();
    mon.delete();
    rc.delete();
    set_list(60, 256, 4);
    drive_list();
    build_exp(2'b10);
    total++;
    if (mon.size() !== exp_q.size()) $display("FAIL resume_count got %0d want %0d", mon.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) $display("FAIL resume[%0d] got %h want %h", i, mon[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_stuck_hi();
    int r0, d0;
    n_rst = 1'b0;
    pwm_in = 1'b1;
    repeat (3) tick();
    n_rst = 1'b1;
    r0 = cyc;
    mon.delete();
    while (cyc < r0 + T + 2) @(negedge clk);
    total++;
    if (stuck_hi !== 1'b0) $display("FAIL stuck_hi_early got %b want 0", stuck_hi);
    else passed++;
    @(negedge clk);
    total++;
    if ({stuck_hi, stuck_lo} !== 2'b10) $display("FAIL stuck_hi_set got %b want 10", {stuck_hi, stuck_lo});
    else passed++;
    total++;
    if (mon.size() !== 0) $display("FAIL stuck_hi_pulses got %0d want 0", mon.size());
    else passed++;
    tick();
    pwm_in = 1'b0;
    d0 = cyc;
    while (cyc < d0 + 2) @(negedge clk);
    total++;
    if ({stuck_hi, stuck_lo} !== 2'b10) $display("FAIL swap_before got %b want 10", {stuck_hi, stuck_lo});
    else passed++;
    @(negedge clk);
    total++;
    if ({stuck_hi, stuck_lo} !== 2'b01) $display("FAIL swap_after got %b want 01", {stuck_hi, stuck_lo});
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_high();
    do_reset(1'b0);
    set_list(100, 256, 4);
    drive_list();
    pwm_in = 1'b1;
    repeat (20) tick();
    total++;
    if (high_cnt !== 16'd100) $display("FAIL mid_pre got %0d want 100", high_cnt);
    else passed++;
    #3 n_rst = 1'b0;
    #1;
    total++;
    if ({meas_valid, high_cnt, period_cnt, duty8, period_ok, stuck_hi, stuck_lo} !== '0)
      $display("FAIL mid_reset got %h want 0", {meas_valid, high_cnt, period_cnt, duty8, period_ok, stuck_hi, stuck_lo});
    else passed++;
    pwm_in = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    mon.delete();
    rc.delete();
    repeat (4) tick();
    set_list(77, 256, 4);
    drive_list();
    build_exp(2'b00);
    total++;
    if (mon.size() !== exp_q.size()) $display("FAIL mid_count got %0d want %0d", mon.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < mon.size(); i++) begin
      total++;
      if (mon[i] !== exp_q[i]) $display("FAIL mid[%0d] got %h want %h", i, mon[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_exclusive();
    total++;
    if (both_seen !== 1'b0) $display("FAIL exclusive got %b want 0", both_seen);
    else passed++;
  endtask

  initial begin
    n_rst = 1'b1;
    pwm_in = 1'b0;
    #2;
    test_reset();
    test_nominal();
    test_duty_extremes();
    test_off_period();
    test_random();
    test_stuck_lo();
    test_stuck_hi();
    test_reset_mid_high();
    test_exclusive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
